// File: rtl/fpdiv_issue_if.sv
// Request and issue buses of the FP divide/sqrt issue stage; master is the environment side, slave is the issue stage.
// Request: a beat transfers on an edge where req_en && req_rdy, and req_rdy never depends on req_en.
// Issue: start_process is a one-cycle pulse raised only while div_rdy is high; every issued field is valid in that cycle.
interface fpdiv_issue_if #(
   parameter int II_WIDTH = 10
);
   logic                req_en;
   logic                req_rdy;
   logic                req_is_root;
   logic [2:0]          req_type;
   logic [2:0]          req_rmode;
   logic [8:0]          req_reg;
   logic [II_WIDTH-1:0] req_II;
   logic [12:0]         req_oper;
   logic                req_signA;
   logic                req_signB;
   logic [15:0]         req_expA;
   logic [15:0]         req_expB;
   logic [63:0]         req_manA;
   logic [63:0]         req_manB;
   logic                div_rdy;
   logic                start_process;
   logic [4:0]          step_cnt;
   logic [2:0]          type_;
   logic                is_root;
   logic [2:0]          rmode;
   logic [8:0]          reg_out;
   logic [II_WIDTH-1:0] outII_out;
   logic [12:0]         oper_out;
   logic [64:0]         normA;
   logic [64:0]         normB;
   logic [16:0]         expA;
   logic [16:0]         expB;
   logic [1:0]          nsignA;
   logic [1:0]          nsignB;

   modport master (
      output req_en, req_is_root, req_type, req_rmode, req_reg, req_II, req_oper,
             req_signA, req_signB, req_expA, req_expB, req_manA, req_manB, div_rdy,
      input  req_rdy, start_process, step_cnt, type_, is_root, rmode, reg_out,
             outII_out, oper_out, normA, normB, expA, expB, nsignA, nsignB
   );

   modport slave (
      input  req_en, req_is_root, req_type, req_rmode, req_reg, req_II, req_oper,
             req_signA, req_signB, req_expA, req_expB, req_manA, req_manB, div_rdy,
      output req_rdy, start_process, step_cnt, type_, is_root, rmode, reg_out,
             outII_out, oper_out, normA, normB, expA, expB, nsignA, nsignB
   );
endinterface

// File: rtl/fpdiv_issue.sv
// Issue stage for the FP divider: buffers requests, normalizes both mantissas,
// then hands one operation at a time to the divider with a single-cycle start pulse.
module fpdiv_issue #(
   parameter int II_WIDTH = 10,
   parameter int DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         except,
   fpdiv_issue_if.slave bus,
   output logic [1:0]   o_dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 191 + II_WIDTH;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, NORM, ISSUE, WAIT} state_t;

   state_t              r_state, w_next;
   logic [EW-1:0]       r_fifo [DEPTH];
   logic [AW:0]         r_wr_ptr, r_rd_ptr;
   logic                w_full, w_empty, w_push, w_pop, w_start, w_load;
   logic [EW-1:0]       w_wdata;

   logic                w_h_is_root, w_h_sign_a, w_h_sign_b;
   logic [2:0]          w_h_type, w_h_rmode;
   logic [8:0]          w_h_reg;
   logic [II_WIDTH-1:0] w_h_ii;
   logic [12:0]         w_h_oper;
   logic [15:0]         w_h_exp_a, w_h_exp_b;
   logic [63:0]         w_h_man_a, w_h_man_b;

   logic                r_is_root, r_sign_a, r_sign_b, r_spec_a, r_spec_b;
   logic [2:0]          r_type, r_rmode;
   logic [8:0]          r_reg;
   logic [II_WIDTH-1:0] r_ii;
   logic [12:0]         r_oper;
   logic [63:0]         r_man_a, r_man_b;
   logic [16:0]         r_exp_a, r_exp_b;
   logic                r_seen_low;
   logic [4:0]          r_wait_cnt;

   logic                w_coarse_a, w_coarse_b;
   logic [3:0]          w_lz_a, w_lz_b;
   logic [63:0]         w_fman_a, w_fman_b;
   logic [16:0]         w_fexp_a, w_fexp_b, w_nexp_a, w_nexp_b;
   logic [64:0]         w_norm_a, w_norm_b;
   logic [4:0]          w_step;

   logic                r_o_is_root;
   logic [4:0]          r_o_step;
   logic [2:0]          r_o_type, r_o_rmode;
   logic [8:0]          r_o_reg;
   logic [II_WIDTH-1:0] r_o_ii;
   logic [12:0]         r_o_oper;
   logic [64:0]         r_o_norm_a, r_o_norm_b;
   logic [16:0]         r_o_exp_a, r_o_exp_b;
   logic [1:0]          r_o_nsign_a, r_o_nsign_b;

   function automatic logic [3:0] lz16(input logic [15:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) n = 4'(15 - i);
      end
      return n;
   endfunction

   // Exponents are 17-bit two's complement; denormals count as exponent 1, zeros as 0.
   function automatic logic [16:0] init_exp(input logic [15:0] e, input logic [63:0] m);
      if (m == 64'd0)      return 17'd0;
      else if (e == 16'd0) return 17'd1;
      else                 return {1'b0, e};
   endfunction

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = bus.req_en && !w_full && !except;
   assign w_pop   = (r_state == IDLE) && !w_empty && !except;
   assign w_wdata = {bus.req_is_root, bus.req_type, bus.req_rmode, bus.req_reg, bus.req_II,
                     bus.req_oper, bus.req_signA, bus.req_signB, bus.req_expA, bus.req_expB,
                     bus.req_manA, bus.req_manB};
   assign {w_h_is_root, w_h_type, w_h_rmode, w_h_reg, w_h_ii, w_h_oper, w_h_sign_a, w_h_sign_b,
           w_h_exp_a, w_h_exp_b, w_h_man_a, w_h_man_b} = r_fifo[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (except) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Inf/NaN and zero operands never shift; the other operand keeps going on its own.
   assign w_coarse_a = !r_spec_a && (r_man_a != 64'd0) && (r_man_a[63:48] == 16'd0);
   assign w_coarse_b = !r_spec_b && (r_man_b != 64'd0) && (r_man_b[63:48] == 16'd0);
   assign w_lz_a     = (r_spec_a || r_man_a == 64'd0) ? 4'd0 : lz16(r_man_a[63:48]);
   assign w_lz_b     = (r_spec_b || r_man_b == 64'd0) ? 4'd0 : lz16(r_man_b[63:48]);
   assign w_fman_a   = r_man_a << w_lz_a;
   assign w_fman_b   = r_man_b << w_lz_b;
   assign w_fexp_a   = r_exp_a - {13'd0, w_lz_a};
   assign w_fexp_b   = r_exp_b - {13'd0, w_lz_b};
   assign w_load     = (r_state == NORM) && !w_coarse_a && !w_coarse_b && !except;

   // An even biased exponent is an odd unbiased one: pre-shift right so sqrt sees an even power.
   always_comb begin
      w_norm_a = {w_fman_a, 1'b0};
      w_nexp_a = w_fexp_a;
      w_norm_b = {w_fman_b, 1'b0};
      w_nexp_b = w_fexp_b;
      if (r_is_root) begin
         if (!w_fexp_a[0]) begin
            w_norm_a = {1'b0, w_fman_a};
            w_nexp_a = w_fexp_a + 17'd1;
         end
         w_norm_b = '0;
         w_nexp_b = '0;
      end
   end

   always_comb begin
      case (r_type)
         3'd2:    w_step = 5'd7;
         3'd1:    w_step = 5'd17;
         default: w_step = 5'd14;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_is_root <= 1'b0; r_sign_a <= 1'b0; r_sign_b <= 1'b0;
         r_spec_a  <= 1'b0; r_spec_b <= 1'b0;
         r_type    <= '0;   r_rmode  <= '0;   r_reg    <= '0;
         r_ii      <= '0;   r_oper   <= '0;
         r_man_a   <= '0;   r_man_b  <= '0;   r_exp_a  <= '0;   r_exp_b <= '0;
      end else if (w_pop) begin
         r_is_root <= w_h_is_root; r_sign_a <= w_h_sign_a; r_sign_b <= w_h_sign_b;
         r_spec_a  <= (w_h_exp_a == 16'hffff);
         r_spec_b  <= (w_h_exp_b == 16'hffff);
         r_type    <= w_h_type; r_rmode <= w_h_rmode; r_reg <= w_h_reg;
         r_ii      <= w_h_ii;   r_oper  <= w_h_oper;
         r_man_a   <= w_h_man_a;
         r_man_b   <= w_h_man_b;
         r_exp_a   <= init_exp(w_h_exp_a, w_h_man_a);
         r_exp_b   <= init_exp(w_h_exp_b, w_h_man_b);
      end else if (r_state == NORM && !except) begin
         if (w_coarse_a) begin
            r_man_a <= {r_man_a[47:0], 16'd0};
            r_exp_a <= r_exp_a - 17'd16;
         end
         if (w_coarse_b) begin
            r_man_b <= {r_man_b[47:0], 16'd0};
            r_exp_b <= r_exp_b - 17'd16;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_o_is_root <= 1'b1;  r_o_step   <= '0;    r_o_type   <= '0;
         r_o_rmode   <= '0;    r_o_reg    <= '0;    r_o_ii     <= '0;
         r_o_oper    <= '0;    r_o_norm_a <= '0;    r_o_norm_b <= '0;
         r_o_exp_a   <= '0;    r_o_exp_b  <= '0;
         r_o_nsign_a <= 2'b01; r_o_nsign_b <= 2'b01;
      end else if (w_load) begin
         r_o_is_root <= r_is_root;
         r_o_step    <= w_step;
         r_o_type    <= (r_type > 3'd2) ? 3'd0 : r_type;
         r_o_rmode   <= r_rmode;
         r_o_reg     <= r_reg;
         r_o_ii      <= r_ii;
         r_o_oper    <= r_oper;
         r_o_norm_a  <= w_norm_a;
         r_o_norm_b  <= w_norm_b;
         r_o_exp_a   <= w_nexp_a;
         r_o_exp_b   <= w_nexp_b;
         r_o_nsign_a <= {1'b0, ~r_sign_a};
         r_o_nsign_b <= {1'b0, ~r_sign_b};
      end
   end

   // WAIT leaves on a low-then-high div_rdy, or after 32 straight high cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seen_low <= 1'b0;
         r_wait_cnt <= '0;
      end else if (w_start) begin
         r_seen_low <= 1'b0;
         r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
         if (!bus.div_rdy) begin
            r_seen_low <= 1'b1;
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      if (except) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:  if (!w_empty) w_next = NORM;
            NORM:  if (!w_coarse_a && !w_coarse_b) w_next = ISSUE;
            ISSUE: if (bus.div_rdy) begin
                      w_next  = WAIT;
                      w_start = 1'b1;
                   end
            WAIT:  if (bus.div_rdy && (r_seen_low || r_wait_cnt == 5'd31)) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   assign bus.req_rdy       = !w_full;
   assign bus.start_process = w_start;
   assign bus.step_cnt      = r_o_step;
   assign bus.type_         = r_o_type;
   assign bus.is_root       = r_o_is_root;
   assign bus.rmode         = r_o_rmode;
   assign bus.reg_out       = r_o_reg;
   assign bus.outII_out     = r_o_ii;
   assign bus.oper_out      = r_o_oper;
   assign bus.normA         = r_o_norm_a;
   assign bus.normB         = r_o_norm_b;
   assign bus.expA          = r_o_exp_a;
   assign bus.expB          = r_o_exp_b;
   assign bus.nsignA        = r_o_nsign_a;
   assign bus.nsignB        = r_o_nsign_b;
   assign o_dbg_state       = r_state;
endmodule
